// File: rtl/bin_to_bcd_ex3.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Each result is given as packed BCD digits and as their digit-wise excess-3 codes.
module bin_to_bcd_ex3 #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [4*DIGITS-1:0]   out_ex3,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Decimal digit count of the largest input value, 2**w - 1.
  function automatic int digits_needed(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
    $error("bin_to_bcd_ex3: BIN_W=%0d outside 1..16", BIN_W);
  end
  if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_ex3: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] to_ex3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ACC_W-1:0]   bcd_q,   bcd_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;

  // Held low during reset so nothing is offered while the block is cleared.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign out_bcd   = bcd_q;
  assign out_ex3   = to_ex3(bcd_q);

  assign acc_adj   = add3_digits(acc_q);
  assign acc_shift = {acc_adj[ACC_W-2:0], shreg_q[BIN_W-1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d = in_bin;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_shift;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Last bit: publish the finished accumulator.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_shift;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

endmodule

// File: doc/bin_to_bcd_ex3.md
# bin_to_bcd_ex3

Sequential binary-to-BCD converter that produces packed BCD digits and their digit-wise excess-3 codes. It feeds the 4-bit excess-3 coding stage: each output digit is a legal 0–9 BCD value that drives that stage, and the per-digit `+3` result is also provided directly. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with valid/ready handshakes on both sides.

## Interface
- `BIN_W`, default 8: width of the binary input. Legal range is 1 to 16.
- `DIGITS`, default 3: number of BCD output digits. Must satisfy `DIGITS >= ceil(BIN_W*log10(2))`. An illegal setting raises an elaboration-time `$error`.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: upstream presents `in_bin`.
- `in_ready`  out  1: block can accept a new value.
- `in_bin`  in  BIN_W: unsigned binary operand.
- `out_valid`  out  1: `out_bcd` and `out_ex3` are valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_bcd`  out  4*DIGITS: packed BCD. Digit 0 (units) is in `[3:0]`.
- `out_ex3`  out  4*DIGITS: per-digit `out_bcd + 4'd3`. Each 4-bit field is in 3..12 (0x3–0xC). Fields are not carry-coupled.
- `busy`  out  1: conversion in progress (state SHIFT).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: load the shift register with `in_bin`, clear the BCD accumulator, set the bit counter to `BIN_W`, and go to SHIFT.
- **SHIFT**, each cycle:
  - Every accumulator digit ≥ 5 gets +3 (4-bit, no carry out of the digit).
  - Then `{acc, shreg}` shifts left by 1.
  - The counter decrements. After the `BIN_W`-th shift, copy the accumulator to the `out_bcd` register and go to DONE.
- **DONE**
  - `out_valid` = 1. `out_bcd` and `out_ex3` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
- `in_bin` is sampled only at acceptance. Later changes are ignored.
- `in_valid` while not in IDLE is not accepted. Upstream must hold it.
- `out_ex3` is combinational from the `out_bcd` register.
- Output in DONE is guaranteed: every digit is 0–9, and the value equals the accepted `in_bin`.
- Counter width is `$clog2(BIN_W+1)`. The accumulator is `4*DIGITS` bits wide.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, `out_valid` = 0, `busy` = 0.
  - `out_bcd` = 0, so `out_ex3` = {DIGITS{4'h3}}.
  - Accumulator and shift register = 0.
  - `in_ready` = 0 while `rst` is high, and 1 from the first cycle after deassertion.
- Latency: with acceptance at edge E0, shifts occur on edges E1..E`BIN_W`. `out_valid` rises after edge E`BIN_W`.
  - For `BIN_W`=8, `out_valid` is high 8 cycles after the accept edge.
- Handshake at DONE: a handshake at edge H sends the block to IDLE, and `in_ready` = 1 in the cycle after H.
  - There is no same-cycle bypass.
  - Minimum period is `BIN_W`+2 cycles per conversion.
- Backpressure: DONE is held indefinitely while `out_ready` = 0. `in_ready` stays 0.
- `out_ready` is ignored while `out_valid` = 0.
- Reset mid-conversion (SHIFT or DONE): the conversion is aborted and the result discarded. Outputs return to their reset values immediately, with no stale `out_valid` after reset.
- `in_valid` and `out_ready` are never both meaningful in the same cycle, because IDLE and DONE are distinct states.

## Test plan
- Accept `in_bin`=0 → after 8 cycles `out_valid`=1, `out_bcd`=0x000, `out_ex3`=0x333.
- Accept 255 → `out_bcd`=0x255, `out_ex3`=0x588. Accept 9 → `out_bcd`=0x009, `out_ex3`=0x33C. Check the 8-cycle latency exactly.
- Backpressure: accept 137 with `out_ready`=0 for 5 cycles, toggling `in_bin` and `in_valid` meanwhile → `out_bcd` stays 0x137 and `in_ready` stays 0. Raise `out_ready` → one handshake, then `in_ready`=1 on the next cycle.
- Back-to-back: hold `in_valid` and `out_ready` high, stream 0..255 exhaustively → each result matches the reference model. Spacing is exactly 10 cycles per result, and no value is dropped or duplicated.
- Reset mid-SHIFT (4 cycles after accepting 200) → `out_valid`=0 and `out_bcd`=0 immediately. After release, accept 42 → 0x042 and 0x375.
- Parameterisation: `BIN_W`=4, `DIGITS`=2. Accept 15 → `out_bcd`=0x15, `out_ex3`=0x48 after 4 cycles.
